dmem_arbiter: RTL and testbench

- Shares the single-port word-organised data memory between two requesters: port 0 (CPU MEM stage) and port 1 (DMA/debug loader).
- Arbitrates between them, sequences one memory access at a time, and adds byte-enable stores through a read-modify-write sequence, since the memory writes only whole words.
- Sits between the requesters and the data memory's clk/mem_wen/mem_ren/mem_addr/mem_data_i/mem_data_o interface. The memory writes on negedge clk and reads combinationally.

---
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter for a single-port word memory, with byte-enable stores done as read-modify-write.
// Optional DMEM_ARB_STATS_EN adds grant and RMW counters.
module dmem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        busy,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_i,
  input  logic [31:0] mem_data_o
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_gnt0,
  output logic [31:0] stat_gnt1,
  output logic [31:0] stat_rmw
`endif
);
  typedef enum logic [1:0] {IDLE, RMW_RD, ACCESS, RESP} state_t;
  state_t state;
  logic port, we_q, last_grant, gnt, g1, we_sel, unused_lsb;
  logic [3:0] be_q, be_sel;
  logic [29:0] word_q;
  logic [31:0] wdata_q, old_word, merged;
  assign gnt = m0_req | m1_req;
  // m1 wins when alone, or on a round-robin tie after m0 was last served
  assign g1 = m1_req & (~m0_req | (!FIXED_PRIO & !last_grant));
  assign we_sel = g1 ? m1_we : m0_we;
  assign be_sel = g1 ? m1_be : m0_be;
  assign unused_lsb = ^{m0_addr[1:0], m1_addr[1:0]};
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++)
      if (be_q[i]) merged[8*i+:8] = wdata_q[8*i+:8];
  end
  // memory strobes depend only on state and latched fields, so they are stable across negedge
  assign busy = state != IDLE;
  assign mem_ren = state == RMW_RD || (state == ACCESS && !we_q);
  assign mem_wen = state == ACCESS && we_q;
  assign mem_addr = {word_q, 2'b00};
  assign mem_data_i = mem_wen ? merged : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      port <= 1'b0;
      we_q <= 1'b0;
      be_q <= '0;
      word_q <= '0;
      wdata_q <= '0;
      old_word <= '0;
      last_grant <= 1'b1;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
`ifdef DMEM_ARB_STATS_EN
      stat_gnt0 <= '0;
      stat_gnt1 <= '0;
      stat_rmw <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (gnt) begin
          port <= g1;
          last_grant <= g1;
          we_q <= we_sel;
          be_q <= be_sel;
          word_q <= g1 ? m1_addr[31:2] : m0_addr[31:2];
          wdata_q <= g1 ? m1_wdata : m0_wdata;
`ifdef DMEM_ARB_STATS_EN
          if (g1) stat_gnt1 <= stat_gnt1 + 32'd1;
          else stat_gnt0 <= stat_gnt0 + 32'd1;
          if (we_sel && be_sel != 4'h0 && be_sel != 4'hF) stat_rmw <= stat_rmw + 32'd1;
`endif
          if (!we_sel || be_sel == 4'hF) state <= ACCESS;
          else if (be_sel == 4'h0) begin
            state <= RESP;
            m0_ack <= !g1;
            m1_ack <= g1;
          end else state <= RMW_RD;
        end
        RMW_RD: begin
          old_word <= mem_data_o;
          state <= ACCESS;
        end
        ACCESS: begin
          state <= RESP;
          m0_ack <= !port;
          m1_ack <= port;
          m0_rdata <= (!port && !we_q) ? mem_data_o : '0;
          m1_rdata <= (port && !we_q) ? mem_data_o : '0;
        end
        default: begin
          state <= IDLE;
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          m0_rdata <= '0;
          m1_rdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized self-checking bench with a transaction-level reference model and a behavioural word memory.
module tb_dmem_arbiter;
  localparam bit FP = 1'b0;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [3:0] m0_be = 0, m1_be = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_ack, m1_ack, busy, mem_wen, mem_ren;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_data_i, mem_data_o;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_gnt0, stat_gnt1, stat_rmw;
`endif
  dmem_arbiter #(.FIXED_PRIO(FP)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .busy(busy), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o)
`ifdef DMEM_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_rmw(stat_rmw)
`endif
  );
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic bd_we = 1'b0;
  logic [7:0] bd_a = 0;
  logic [31:0] bd_d = 0;
  assign mem_data_o = mem[mem_addr[9:2]];
  always @(negedge clk)
    if (bd_we) mem[bd_a] <= bd_d;
    else if (mem_wen) mem[mem_addr[9:2]] <= mem_data_i;
  int tests = 0, fails = 0;
  bit lg;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    bd_a = a;
    bd_d = d;
    bd_we = 1'b1;
    @(negedge clk);
    #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask
  task automatic drive(input int p, input logic r, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] w);
    if (p == 0) begin
      m0_req = r; m0_we = we; m0_be = be; m0_addr = a; m0_wdata = w;
    end else begin
      m1_req = r; m1_we = we; m1_be = be; m1_addr = a; m1_wdata = w;
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick;
    rst = 1'b0;
    lg = 1'b1;
  endtask
  function automatic int lat(input logic we, input logic [3:0] be);
    return !we ? 2 : be == 4'h0 ? 1 : be == 4'hF ? 2 : 3;
  endfunction
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    tests++;
    if ({busy, m0_ack, m1_ack, mem_wen, mem_ren, m0_rdata, m1_rdata, mem_addr, mem_data_i} !== '0) begin
      fails++;
      $display("FAIL reset_outputs busy=%0b acks=%0b%0b wen=%0b ren=%0b addr=%h want all zero",
               busy, m0_ack, m1_ack, mem_wen, mem_ren, mem_addr);
    end
`ifdef DMEM_ARB_STATS_EN
    tests++;
    if ({stat_gnt0, stat_gnt1, stat_rmw} !== '0) begin
      fails++;
      $display("FAIL reset_stats got %0d %0d %0d want 0 0 0", stat_gnt0, stat_gnt1, stat_rmw);
    end
`endif
    rst = 1'b0;
    lg = 1'b1;
  endtask
  task automatic test_read_latency;
    poke(8'd4, 32'hDEADBEEF);
    drive(0, 1, 0, 4'hF, 32'h10, 0);
    tick;
    tests++;
    if ({mem_ren, mem_wen, busy, m0_ack, m1_ack} !== 5'b10100 || mem_addr !== 32'h10) begin
      fails++;
      $display("FAIL read_c1 ren/wen/busy/ack0/ack1=%b addr=%h want 10100 addr=00000010",
               {mem_ren, mem_wen, busy, m0_ack, m1_ack}, mem_addr);
    end
    tick;
    tests++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL read_c2 ack0=%b ack1=%b rdata=%h want 1 0 deadbeef", m0_ack, m1_ack, m0_rdata);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick;
    tests++;
    if (busy !== 1'b0 || m0_ack !== 1'b0) begin
      fails++;
      $display("FAIL read_c3 busy=%b ack0=%b want 0 0", busy, m0_ack);
    end
  endtask
  task automatic test_tie;
    do_reset;
    poke(8'd5, 32'hCAFEF00D);
    drive(0, 1, 0, 4'hF, 32'h10, 0);
    drive(1, 1, 0, 4'hF, 32'h14, 0);
    for (int c = 1; c <= 7; c++) begin
      tick;
      tests++;
      if ({m0_ack, m1_ack} !== {c == 2, c == 5}) begin
        fails++;
        $display("FAIL tie_ack cycle %0d got %b%b want %b%b", c, m0_ack, m1_ack, c == 2, c == 5);
      end
      if (c == 2) begin
        tests++;
        if (m0_rdata !== ref_mem[4]) begin
          fails++;
          $display("FAIL tie_rdata0 got %h want %h", m0_rdata, ref_mem[4]);
        end
        m0_req = 1'b0;
      end
      if (c == 5) begin
        tests++;
        if (m1_rdata !== ref_mem[5]) begin
          fails++;
          $display("FAIL tie_rdata1 got %h want %h", m1_rdata, ref_mem[5]);
        end
        m1_req = 1'b0;
      end
    end
  endtask
  task automatic test_round_robin;
    int order[8];
    int n = 0;
    do_reset;
    drive(0, 1, 0, 4'hF, 32'h10, 0);
    drive(1, 1, 0, 4'hF, 32'h14, 0);
    for (int c = 0; c < 80 && n < 8; c++) begin
      tick;
      if (m0_ack && m1_ack) begin
        fails++;
        $display("FAIL rr_double_ack both acks high at cycle %0d want one", c);
      end
      if (m0_ack || m1_ack) order[n++] = m1_ack ? 1 : 0;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tests++;
    if (n != 8) begin
      fails++;
      $display("FAIL rr_count got %0d acks want 8", n);
    end
    for (int i = 0; i < n; i++) begin
      tests++;
      if (order[i] != (FP ? 0 : i % 2)) begin
        fails++;
        $display("FAIL rr_order txn %0d got port %0d want %0d", i, order[i], FP ? 0 : i % 2);
      end
    end
    tick;
    tick;
  endtask
  task automatic test_partial_write;
    poke(8'd8, 32'h11223344);
    drive(1, 1, 1, 4'b0010, 32'h20, 32'h0000AA00);
    tick;
    tests++;
    if ({mem_ren, mem_wen, busy, m0_ack, m1_ack} !== 5'b10100) begin
      fails++;
      $display("FAIL pw_rmw_rd ren/wen/busy/ack0/ack1=%b want 10100", {mem_ren, mem_wen, busy, m0_ack, m1_ack});
    end
    tick;
    tests++;
    if ({mem_ren, mem_wen} !== 2'b01 || mem_data_i !== 32'h1122AA44 || mem_addr !== 32'h20) begin
      fails++;
      $display("FAIL pw_write ren/wen=%b data=%h addr=%h want 01 1122aa44 00000020",
               {mem_ren, mem_wen}, mem_data_i, mem_addr);
    end
    tick;
    tests++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || m1_rdata !== 32'h0 || mem_wen !== 1'b0) begin
      fails++;
      $display("FAIL pw_ack ack1=%b ack0=%b rdata=%h wen=%b want 1 0 0 0", m1_ack, m0_ack, m1_rdata, mem_wen);
    end
    drive(1, 0, 0, 0, 0, 0);
    ref_mem[8] = 32'h1122AA44;
    tick;
    drive(0, 1, 0, 4'hF, 32'h22, 0);
    tick;
    tick;
    tests++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'h1122AA44) begin
      fails++;
      $display("FAIL pw_readback ack=%b rdata=%h want 1 1122aa44", m0_ack, m0_rdata);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick;
  endtask
  task automatic test_zero_be;
    drive(0, 1, 1, 4'h0, 32'h20, 32'hFFFFFFFF);
    tick;
    tests++;
    if ({m0_ack, m1_ack, mem_ren, mem_wen} !== 4'b1000 || m0_rdata !== 32'h0) begin
      fails++;
      $display("FAIL zbe_ack ack0/ack1/ren/wen=%b rdata=%h want 1000 0", {m0_ack, m1_ack, mem_ren, mem_wen}, m0_rdata);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick;
    tests++;
    if (busy !== 1'b0 || mem[8] !== ref_mem[8]) begin
      fails++;
      $display("FAIL zbe_after busy=%b word=%h want 0 %h", busy, mem[8], ref_mem[8]);
    end
  endtask
  task automatic test_reset_mid_rmw;
    drive(0, 1, 1, 4'b0001, 32'h20, 32'h000000FF);
    tick;
    tests++;
    if ({mem_ren, mem_wen, busy} !== 3'b101) begin
      fails++;
      $display("FAIL rst_rmw_enter ren/wen/busy=%b want 101", {mem_ren, mem_wen, busy});
    end
    rst = 1'b1;
    m0_req = 1'b0;
    tick;
    rst = 1'b0;
    lg = 1'b1;
    tests++;
    if ({busy, mem_wen, mem_ren, m0_ack, m1_ack} !== 5'b0) begin
      fails++;
      $display("FAIL rst_rmw_state busy/wen/ren/ack0/ack1=%b want 00000", {busy, mem_wen, mem_ren, m0_ack, m1_ack});
    end
`ifdef DMEM_ARB_STATS_EN
    tests++;
    if (stat_rmw !== 32'd0) begin
      fails++;
      $display("FAIL rst_rmw_stat got %0d want 0", stat_rmw);
    end
`endif
    for (int c = 0; c < 4; c++) begin
      tick;
      tests++;
      if ({mem_wen, m0_ack, m1_ack} !== 3'b0) begin
        fails++;
        $display("FAIL rst_rmw_quiet cycle %0d wen/ack0/ack1=%b want 000", c, {mem_wen, m0_ack, m1_ack});
      end
    end
    tests++;
    if (mem[8] !== ref_mem[8]) begin
      fails++;
      $display("FAIL rst_rmw_mem got %h want %h", mem[8], ref_mem[8]);
    end
  endtask
  task automatic test_random;
    logic act[2], rwe[2];
    logic [3:0] rbe[2];
    logic [31:0] raddr[2], rwd[2], erd[2];
    int eack[2], seq[2];
    int ns, first, sel, last_c, g0 = 0, g1 = 0, rmw = 0;
    do_reset;
    for (int r = 0; r < 150; r++) begin
      sel = $urandom_range(0, 2);
      act[0] = sel != 1;
      act[1] = sel != 0;
      for (int p = 0; p < 2; p++) begin
        rwe[p] = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 3);
        rbe[p] = sel == 0 ? 4'h0 : sel == 1 ? 4'hF : 4'($urandom);
        raddr[p] = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        rwd[p] = $urandom;
        eack[p] = 0;
        erd[p] = 0;
      end
      first = (act[0] && act[1]) ? (FP ? 0 : (lg ? 0 : 1)) : (act[0] ? 0 : 1);
      seq[0] = first;
      seq[1] = 1 - first;
      ns = (act[0] && act[1]) ? 2 : 1;
      for (int k = 0; k < ns; k++) begin
        automatic int p = seq[k];
        automatic int idx = raddr[p][9:2];
        if (rwe[p]) begin
          for (int b = 0; b < 4; b++)
            if (rbe[p][b]) ref_mem[idx][8*b+:8] = rwd[p][8*b+:8];
          if (rbe[p] != 4'h0 && rbe[p] != 4'hF) rmw++;
        end else erd[p] = ref_mem[idx];
        eack[p] = (k == 0 ? 0 : eack[seq[0]] + 1) + lat(rwe[p], rbe[p]);
        if (p == 0) g0++;
        else g1++;
        lg = p[0];
      end
      for (int p = 0; p < 2; p++) drive(p, act[p], rwe[p], rbe[p], raddr[p], rwd[p]);
      last_c = eack[seq[ns-1]] + 1;
      for (int c = 1; c <= last_c; c++) begin
        tick;
        for (int p = 0; p < 2; p++) begin
          automatic logic a = p ? m1_ack : m0_ack;
          automatic logic [31:0] d = p ? m1_rdata : m0_rdata;
          automatic logic e = act[p] && c == eack[p];
          tests++;
          if (a !== e) begin
            fails++;
            $display("FAIL rand_ack round %0d port %0d cycle %0d got %b want %b", r, p, c, a, e);
          end
          tests++;
          if (d !== (e ? erd[p] : 32'h0)) begin
            fails++;
            $display("FAIL rand_rdata round %0d port %0d cycle %0d got %h want %h", r, p, c, d, e ? erd[p] : 32'h0);
          end
          if (e) drive(p, 0, 0, 0, 0, 0);
        end
      end
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL rand_idle round %0d busy=%b want 0", r, busy);
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
    end
    tick;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (mem[i] !== ref_mem[i]) begin
        fails++;
        $display("FAIL rand_mem word %0d got %h want %h", i, mem[i], ref_mem[i]);
      end
    end
`ifdef DMEM_ARB_STATS_EN
    tests++;
    if (stat_gnt0 !== g0 || stat_gnt1 !== g1 || stat_rmw !== rmw) begin
      fails++;
      $display("FAIL rand_stats got %0d %0d %0d want %0d %0d %0d", stat_gnt0, stat_gnt1, stat_rmw, g0, g1, rmw);
    end
`endif
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
    test_reset;
    test_read_latency;
    test_tie;
    test_round_robin;
    test_partial_write;
    test_zero_be;
    test_reset_mid_rmw;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
